// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, controller condition codes,
// and the default boot address.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_ISSUE = 2'd2
  } fetch_state_e;

  // Branch condition encoding driven by controller.condition
  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_EQ   = 3'b001;
  localparam logic [2:0] COND_NE   = 3'b010;
  localparam logic [2:0] COND_LT   = 3'b110;
  localparam logic [2:0] COND_GE   = 3'b011;
  localparam logic [2:0] COND_LE   = 3'b101;
  localparam logic [2:0] COND_GT   = 3'b100;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: absolute jump beats a taken branch, which beats pc+4.
// Only IR[25:0] matters here (jump index; its low half is the branch offset).
module pc_next
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] ir_i,
  input  logic        jump_i,
  input  logic [2:0]  condition_i,
  input  logic        alu_zero_i,
  input  logic        alu_sign_i,
  output logic [31:0] next_pc_o,
  output logic        branch_taken_o
);

  logic [31:0] br_target;
  logic [31:0] jmp_target;

  // Offset is a word count; shifting by 2 keeps targets word-aligned
  assign br_target  = pc_plus4_i + {{14{ir_i[15]}}, ir_i[15:0], 2'b00};
  assign jmp_target = {pc_plus4_i[31:28], ir_i, 2'b00};

  // Decode the controller condition against the ALU compare flags
  always_comb begin
    branch_taken_o = 1'b0;
    case (condition_i)
      COND_EQ: branch_taken_o = alu_zero_i;
      COND_NE: branch_taken_o = !alu_zero_i;
      COND_LT: branch_taken_o = alu_sign_i;
      COND_GE: branch_taken_o = !alu_sign_i;
      COND_LE: branch_taken_o = alu_sign_i | alu_zero_i;
      COND_GT: branch_taken_o = !alu_sign_i & !alu_zero_i;
      default: branch_taken_o = 1'b0; // NONE and unused 111
    endcase
  end

  // Priority mux for the redirect
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i)              next_pc_o = jmp_target;
    else if (branch_taken_o) next_pc_o = br_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from imem, instruction register
// and retired-instruction counter. No delay slots; redirects hit the next fetch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Jump,
  input  logic [2:0]  condition,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        exec_done,
  output logic [31:0] retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, ir_q, retired_q;
  logic         req_q, vld_q;
  logic [31:0]  next_pc;
  logic         unused_branch_taken;
  logic         fetch_done, issue_done;

  assign fetch_done = (state_q == FS_FETCH) && imem_ack;
  assign issue_done = (state_q == FS_ISSUE) && exec_done;

  assign pc_plus4  = pc_q + 32'd4;  // wraps naturally at 2^32
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign IR        = ir_q;
  assign ir_valid  = vld_q;
  assign retired   = retired_q;

  pc_next u_pc_next (
    .pc_plus4_i     (pc_plus4),
    .ir_i           (ir_q[25:0]),
    .jump_i         (Jump),
    .condition_i    (condition),
    .alu_zero_i     (alu_zero),
    .alu_sign_i     (alu_sign),
    .next_pc_o      (next_pc),
    .branch_taken_o (unused_branch_taken)
  );

  // FSM next state; acks and exec_done outside their own state are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_BOOT:  state_d = FS_FETCH;
      FS_FETCH: if (imem_ack)  state_d = FS_ISSUE;
      FS_ISSUE: if (exec_done) state_d = FS_FETCH;
      default:  state_d = FS_BOOT;
    endcase
  end

  // State, registered req/valid outputs, IR capture, PC update and retire count.
  // Reset wins over any simultaneous ack/exec_done, dropping the open fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FS_BOOT;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      retired_q <= 32'h0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == FS_FETCH);
      vld_q   <= (state_d == FS_ISSUE);
      if (fetch_done) ir_q <= imem_rdata;
      if (issue_done) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-issue MIPS core, directly upstream of `controller`. It holds the PC, runs a request/acknowledge fetch from instruction memory, and latches the fetched word into the instruction register that `controller` decodes combinationally. It computes the next PC from the `controller` outputs `Jump` and `condition`, plus the ALU compare flags, and counts retired instructions. There are no branch delay slots: a taken branch or jump redirects the very next fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  the only clock; every flop is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req`  out  1  fetch request; registered; high exactly while in FETCH.
- `imem_addr`  out  32  byte address being fetched; equals `pc`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `imem_ack`  in  1  memory has delivered `imem_rdata`; ignored outside FETCH.
- `IR`  out  32  instruction register, fed to `controller.IR`.
- `ir_valid`  out  1  `IR` holds the instruction under execution (state ISSUE).
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc`+4, used as the link value by JAL-class writes.
- `Jump`  in  1  from `controller`; absolute jump.
- `condition`  in  3  from `controller`. Codes: 000 none, 001 eq, 010 ne, 110 lt, 011 ge, 101 le, 100 gt.
- `alu_zero`  in  1  ALU result is zero (the SUBU compare).
- `alu_sign`  in  1  MSB of the ALU result.
- `exec_done`  in  1  datapath has finished the instruction in `IR`; sampled only in ISSUE.
- `retired`  out  32  count of completed instructions.

## Operation
- States: BOOT, FETCH, ISSUE.
- BOOT → FETCH unconditionally.
- FETCH → ISSUE on `imem_ack`. On that edge, `IR`<=`imem_rdata`.
- ISSUE → FETCH on `exec_done`. On that edge, `pc`<=next_pc and `retired`<=`retired`+1.
- Branch taken, by `condition`:
  - eq: zero
  - ne: !zero
  - lt: sign
  - ge: !sign
  - le: sign|zero
  - gt: !sign & !zero
  - 000 and unused code 111: never taken.
- next_pc priority:
  1. `Jump`=1: {pc_plus4[31:28], IR[25:0], 2'b00}
  2. branch taken: pc_plus4 + (sign-extended IR[15:0] << 2), modulo 2^32
  3. otherwise: pc_plus4
- Width rules:
  - `pc[1:0]` is always 00, because every target is word-aligned by construction.
  - `pc_plus4` wraps from 32'hFFFF_FFFC to 0.
  - `retired` wraps from 32'hFFFF_FFFF to 0.
- `imem_ack` in BOOT or ISSUE: ignored, no state change.
- `exec_done` in BOOT or FETCH: ignored.
- `Jump`/`condition`/flags are only used in the ISSUE cycle where `exec_done`=1.

## Timing
- Reset values:
  - state = BOOT
  - `pc` = RESET_PC
  - `IR` = 0 (sll $0,$0,0, a NOP)
  - `ir_valid` = 0
  - `imem_req` = 0
  - `retired` = 0
- Sequence after reset:
  - The first cycle with `rst`=0 is BOOT, with `imem_req`=0.
  - `imem_req`=1 from the next cycle.
- `imem_ack` may arrive in the same cycle `imem_req` first rises, so FETCH takes at least 1 cycle. ISSUE takes at least 1 cycle. Peak throughput is 1 instruction per 2 cycles.
- `imem_addr` is stable for the whole FETCH interval, and `imem_req` holds high until the ack.
- `ir_valid` rises the cycle after the ack and falls the cycle after `exec_done`.
- Reset mid-operation takes priority over any simultaneous ack or `exec_done`. An outstanding fetch is abandoned, and memory must tolerate the dropped request.

## Structure
- Shared package `cpu_pkg`:
  - fetch state enum
  - condition-code constants (COND_NONE/EQ/NE/LT/GE/LE/GT)
  - default RESET_PC
- The `controller` condition encoding is imported from `cpu_pkg`, not duplicated.
- One combinational sub-module, `pc_next`: takes pc_plus4, IR, `Jump`, `condition`, `alu_zero` and `alu_sign`, and produces next_pc and `branch_taken`.
- The FSM, PC, IR and counter live in `fetch_unit`.

## Test plan
- Reset release with RESET_PC=32'h100, memory ack at 0 latency → BOOT 1 cycle, then `imem_req`=1 with `imem_addr`=32'h100. Next cycle `IR`=rdata and `ir_valid`=1.
- Sequential flow: `exec_done` pulses, no jump or branch → fetches go to 0x100, 0x104, 0x108. `retired`=3 after the third `exec_done`.
- BEQ with IR[15:0]=16'hFFFE, condition=001, alu_zero=1, at pc=0x200 → next fetch address 0x1FC. With alu_zero=0 → 0x204.
- Jump with IR[25:0]=26'h0000040 at pc=0x1000_0010 → next fetch address 0x1000_0100. `Jump`=1 together with a taken branch → the jump target wins.
- Memory latency of 5 cycles, with a spurious ack and `exec_done` injected in the wrong states → `imem_req` and `imem_addr` stay stable for 5 cycles, and the spurious inputs are ignored.
- `rst` asserted in the middle of FETCH while `imem_ack`=1 in the same cycle → `IR` stays 0, `pc`=RESET_PC, `retired`=0, BOOT follows. Also preload pc=0xFFFF_FFFC with no branch → the next fetch address is 0.
